// File: rtl/tdc_clk_pkg.sv
// Shared types and constants for the TDC calibration clocking blocks.
package tdc_clk_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_DWELL, S_NEXT, S_FIN
  } state_t;

  localparam int CNTSEL_W = 5;
  localparam logic UP = 1'b1;
  localparam logic DN = 1'b0;
  localparam logic [CNTSEL_W-1:0] CNTSEL_EIGHTH = 5'b00001;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/phase_step_timer.sv
// Loadable down-counter that saturates at zero; shared dwell/timeout timer.
module phase_step_timer #(
  parameter int W = 16
) (
  input  logic         scanclk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         zero_nxt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge scanclk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign zero     = (cnt_q == '0);
  assign zero_nxt = (cnt_d == '0);
endmodule

// File: rtl/phase_sweep_sequencer.sv
// Drives the DPLL dynamic-phase FSM through a programmed sweep of single phase
// steps, dwelling after each forward step and optionally returning to start.
module phase_sweep_sequencer
  import tdc_clk_pkg::*;
#(
  parameter int STEP_W      = 8,
  parameter int DWELL_W     = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                scanclk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [STEP_W-1:0]   cfg_steps,
  input  logic                cfg_dir,
  input  logic [CNTSEL_W-1:0] cfg_cntsel,
  input  logic [DWELL_W-1:0]  cfg_dwell,
  input  logic                cfg_return,
  input  logic                dpll_done,
  output logic                change_phase,
  output logic [CNTSEL_W-1:0] cntsel,
  output logic                updn,
  output logic                capture_strobe,
  output logic [STEP_W-1:0]   step_idx,
  output logic                busy,
  output logic                sweep_done,
  output logic                err_timeout
);
  localparam int TMR_W = max_i(DWELL_W, $clog2(TIMEOUT_CYC));
  localparam logic [TMR_W-1:0] TMO_LD = TMR_W'(TIMEOUT_CYC - 1);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   steps_q, steps_d, step_idx_q, step_idx_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                dir_q, dir_d, ret_en_q, ret_en_d, ret_ph_q, ret_ph_d;
  logic [CNTSEL_W-1:0] cntsel_q, cntsel_d;
  logic                updn_q, updn_d, err_q, err_d;
  logic                change_phase_q, change_phase_d, capture_q, capture_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                tmr_load, tmr_dec, tmr_zero, tmr_zero_nxt;
  logic [TMR_W-1:0]    tmr_val, dwell_ld;

  // A programmed dwell of 0 behaves as 1 cycle.
  assign dwell_ld = (dwell_q == '0) ? '0 : TMR_W'(dwell_q) - 1'b1;

  phase_step_timer #(.W(TMR_W)) u_tmr (
    .scanclk  (scanclk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero),
    .zero_nxt (tmr_zero_nxt)
  );

  always_comb begin
    state_d    = state_q;
    steps_d    = steps_q;
    dwell_d    = dwell_q;
    dir_d      = dir_q;
    ret_en_d   = ret_en_q;
    ret_ph_d   = ret_ph_q;
    cntsel_d   = cntsel_q;
    updn_d     = updn_q;
    err_d      = err_q;
    step_idx_d = step_idx_q;
    tmr_load   = 1'b0;
    tmr_val    = TMO_LD;
    tmr_dec    = 1'b0;
    case (state_q)
      S_IDLE: if (start && !abort) begin
        steps_d    = cfg_steps;
        dwell_d    = cfg_dwell;
        dir_d      = cfg_dir;
        ret_en_d   = cfg_return;
        ret_ph_d   = 1'b0;
        cntsel_d   = cfg_cntsel;
        updn_d     = cfg_dir ? UP : DN;
        err_d      = 1'b0;
        step_idx_d = '0;
        state_d    = (cfg_steps == '0) ? S_FIN : S_ISSUE;
      end
      S_ISSUE: begin
        tmr_load = 1'b1;
        state_d  = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        tmr_dec = 1'b1;
        if (!dpll_done)    state_d = S_WAIT_HI;
        else if (tmr_zero) begin err_d = 1'b1; state_d = S_IDLE; end
      end
      S_WAIT_HI: begin
        tmr_dec = 1'b1;
        if (dpll_done) begin
          if (ret_ph_q) begin
            step_idx_d = step_idx_q - 1'b1;
            state_d    = S_NEXT;
          end else begin
            step_idx_d = step_idx_q + 1'b1;
            tmr_load   = 1'b1;
            tmr_val    = dwell_ld;
            state_d    = S_DWELL;
          end
        end else if (tmr_zero) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DWELL: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (!ret_ph_q) begin
          if (step_idx_q < steps_q) state_d = S_ISSUE;
          else if (ret_en_q) begin
            ret_ph_d = 1'b1;
            updn_d   = ~dir_q;
            state_d  = S_ISSUE;
          end else state_d = S_FIN;
        end else begin
          state_d = (step_idx_q != '0) ? S_ISSUE : S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything: freeze position and error, drop to IDLE.
    if (abort) begin
      state_d    = S_IDLE;
      step_idx_d = step_idx_q;
      err_d      = err_q;
      updn_d     = updn_q;
      ret_ph_d   = ret_ph_q;
      tmr_load   = 1'b0;
      tmr_dec    = 1'b0;
    end
    change_phase_d = (state_d == S_ISSUE);
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_FIN);
    capture_d      = (state_d == S_DWELL) && tmr_zero_nxt;
  end

  always_ff @(posedge scanclk or negedge rst_n)
    if (!rst_n) begin
      state_q        <= S_IDLE;
      steps_q        <= '0;
      dwell_q        <= '0;
      dir_q          <= 1'b0;
      ret_en_q       <= 1'b0;
      ret_ph_q       <= 1'b0;
      cntsel_q       <= '0;
      updn_q         <= 1'b0;
      err_q          <= 1'b0;
      step_idx_q     <= '0;
      change_phase_q <= 1'b0;
      capture_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      steps_q        <= steps_d;
      dwell_q        <= dwell_d;
      dir_q          <= dir_d;
      ret_en_q       <= ret_en_d;
      ret_ph_q       <= ret_ph_d;
      cntsel_q       <= cntsel_d;
      updn_q         <= updn_d;
      err_q          <= err_d;
      step_idx_q     <= step_idx_d;
      change_phase_q <= change_phase_d;
      capture_q      <= capture_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end

  assign change_phase   = change_phase_q;
  assign cntsel         = cntsel_q;
  assign updn           = updn_q;
  assign capture_strobe = capture_q;
  assign step_idx       = step_idx_q;
  assign busy           = busy_q;
  assign sweep_done     = done_q;
  assign err_timeout    = err_q;
endmodule

// File: tb/tb_phase_sweep_sequencer.sv
// Bench for phase_sweep_sequencer: DPLL model plus a per-cycle expected
// output schedule derived from step/dwell/latency arithmetic.
module tb_phase_sweep_sequencer;
  import tdc_clk_pkg::*;

  logic scanclk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] cfg_steps = '0;
  logic cfg_dir = 1'b0, cfg_return = 1'b0, dpll_done = 1'b1;
  logic [4:0] cfg_cntsel = '0;
  logic [15:0] cfg_dwell = '0;
  logic change_phase, updn, capture_strobe, busy, sweep_done, err_timeout;
  logic [4:0] cntsel;
  logic [7:0] step_idx;

  phase_sweep_sequencer dut (
    .scanclk(scanclk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_steps(cfg_steps), .cfg_dir(cfg_dir), .cfg_cntsel(cfg_cntsel),
    .cfg_dwell(cfg_dwell), .cfg_return(cfg_return), .dpll_done(dpll_done),
    .change_phase(change_phase), .cntsel(cntsel), .updn(updn),
    .capture_strobe(capture_strobe), .step_idx(step_idx), .busy(busy),
    .sweep_done(sweep_done), .err_timeout(err_timeout)
  );

  always #5 scanclk = ~scanclk;

  typedef struct packed {
    logic cp, st, sd, bz, err, u;
    logic [7:0] idx;
    logic [4:0] cs;
  } obs_t;

  obs_t exp_q[$];
  int cyc = 0, base = 0, chk_len = 0, n_chk = 0, n_fail = 0, sd_cnt = 0, sweep_no = 0;
  int dpll_n = 4, dcnt = 0;
  bit chk_en = 0, dpll_hold = 0;

  function automatic obs_t cur();
    return {change_phase, capture_strobe, sweep_done, busy, err_timeout, updn, step_idx, cntsel};
  endfunction

  always @(posedge scanclk) cyc <= cyc + 1;

  // DPLL: done drops the cycle after change_phase and rises dpll_n cycles later.
  always @(negedge scanclk) begin
    if (!rst_n) dcnt = 0;
    else if (dpll_hold) dpll_done = 1'b1;
    else if (change_phase) begin dpll_done = 1'b0; dcnt = dpll_n; end
    else if (dcnt > 0) begin dcnt--; if (dcnt == 0) dpll_done = 1'b1; end
  end

  always begin
    int t;
    @(posedge scanclk); #1;
    if (sweep_done) sd_cnt++;
    t = cyc - base;
    if (chk_en && t >= 0 && t < chk_len) begin
      n_chk++;
      if (cur() !== exp_q[t]) begin
        n_fail++;
        $display("FAIL sweep%0d cyc%0d outputs: got %h want %h", sweep_no, t, cur(), exp_q[t]);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  task automatic push(input int n, input bit cp, input bit st, input bit sd, input bit bz,
                      input bit u, input int idx, input logic [4:0] cs);
    repeat (n) exp_q.push_back({cp, st, sd, bz, 1'b0, u, 8'(idx), cs});
  endtask

  // Forward step: ISSUE, N waits, dwell (strobe on last), NEXT. Return: ISSUE, N waits, NEXT.
  task automatic build(input int s, input int d, input int n, input bit ret, input bit dir,
                       input logic [4:0] cs);
    int de, fi;
    bit u;
    exp_q.delete();
    de = (d == 0) ? 1 : d;
    u = dir;
    for (int i = 1; i <= s; i++) begin
      push(1, 1, 0, 0, 1, u, i-1, cs);
      push(n, 0, 0, 0, 1, u, i-1, cs);
      if (de > 1) push(de-1, 0, 0, 0, 1, u, i, cs);
      push(1, 0, 1, 0, 1, u, i, cs);
      push(1, 0, 0, 0, 1, u, i, cs);
    end
    fi = s;
    if (ret && s > 0) begin
      u = ~dir;
      for (int i = s; i >= 1; i--) begin
        push(1, 1, 0, 0, 1, u, i, cs);
        push(n, 0, 0, 0, 1, u, i, cs);
        push(1, 0, 0, 0, 1, u, i-1, cs);
      end
      fi = 0;
    end
    push(1, 0, 0, 1, 1, u, fi, cs);
    push(3, 0, 0, 0, 0, u, fi, cs);
  endtask

  // mid: cycle to re-pulse start while busy (-1 none); ab: cycle to abort (-1 none).
  task automatic run_sweep(input int s, input int d, input int n, input bit ret, input bit dir,
                           input logic [4:0] cs, input int cut, input int mid, input int ab);
    build(s, d, n, ret, dir, cs);
    dpll_n = n;
    sweep_no++;
    chk_len = (cut > 0 && cut < exp_q.size()) ? cut : exp_q.size();
    if (mid == -2) mid = $urandom_range(exp_q.size() - 4, 0);
    @(negedge scanclk);
    cfg_steps = 8'(s); cfg_dwell = 16'(d); cfg_dir = dir; cfg_return = ret; cfg_cntsel = cs;
    start = 1'b1; abort = 1'b0;
    base = cyc + 1; chk_en = 1;
    for (int k = 0; k < chk_len; k++) begin
      @(negedge scanclk);
      start = (k == mid) || (k == ab);
      abort = (k == ab);
      cfg_steps = 8'($urandom); cfg_dwell = 16'($urandom); cfg_dir = 1'($urandom);
      cfg_return = 1'($urandom); cfg_cntsel = 5'($urandom);
    end
    chk_en = 0;
  endtask

  initial begin
    int sd0, b;
    #23;
    chk("reset outputs", int'(cur()), 0);
    @(negedge scanclk) rst_n = 1'b1;
    repeat (2) @(negedge scanclk);
    chk("idle after reset", int'(cur()), 0);

    build(3, 4, 10, 0, 1, CNTSEL_EIGHTH);
    chk("model t1 len", exp_q.size(), 52);
    chk("model t1 strobe@14", int'(exp_q[14].st), 1);
    chk("model t1 done@48", int'(exp_q[48].sd), 1);
    build(2, 3, 5, 1, 0, 5'h3);
    chk("model t2 updn@19", int'(exp_q[19].u), 0);
    chk("model t2 updn@20", int'(exp_q[20].u), 1);
    chk("model t2 idx@26", int'(exp_q[26].idx), 1);
    chk("model t2 done@34", int'(exp_q[34].sd), 1);

    run_sweep(3, 4, 10, 0, 1, CNTSEL_EIGHTH, 0, 7, -1);
    run_sweep(2, 3, 5, 1, 0, 5'h3, 0, -1, -1);
    run_sweep(0, 2, 4, 1, 1, 5'h1f, 0, 0, -1);
    run_sweep(2, 0, 2, 1, 1, 5'h05, 0, -1, -1);

    // Timeout: DPLL never leaves DONE.
    dpll_hold = 1;
    @(negedge scanclk);
    cfg_steps = 8'd1; cfg_dwell = 16'd1; start = 1'b1; b = cyc + 1; sd0 = sd_cnt;
    @(negedge scanclk) start = 1'b0;
    while (cyc - b < 4096) @(negedge scanclk);
    chk("tmo busy@4096", int'(busy), 1);
    chk("tmo err@4096", int'(err_timeout), 0);
    @(negedge scanclk);
    chk("tmo busy@4097", int'(busy), 0);
    chk("tmo err@4097", int'(err_timeout), 1);
    chk("tmo no sweep_done", sd_cnt, sd0);
    dpll_hold = 0;
    run_sweep(1, 2, 3, 0, 0, 5'h2, 0, -1, -1);

    // Abort in DWELL of step 2 with a simultaneous start.
    sd0 = sd_cnt;
    run_sweep(3, 5, 4, 0, 1, 5'h1, 18, -1, 17);
    @(negedge scanclk);
    start = 1'b0; abort = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort step_idx", int'(step_idx), 2);
    chk("abort change_phase", int'(change_phase), 0);
    @(negedge scanclk);
    chk("abort start ignored", int'(busy), 0);
    chk("abort no sweep_done", sd_cnt, sd0);

    for (int r = 0; r < 10; r++)
      run_sweep($urandom_range(4, 0), $urandom_range(5, 0), $urandom_range(8, 2),
                1'($urandom), 1'($urandom), 5'($urandom), 0, -2, -1);

    // Asynchronous reset in WAIT_HI.
    run_sweep(2, 3, 10, 0, 1, 5'h9, 6, -1, -1);
    @(negedge scanclk);
    chk("pre-reset busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", int'(cur()), 0);
    @(negedge scanclk) rst_n = 1'b1;
    run_sweep(1, 1, 2, 1, 0, 5'h4, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
